// File: rtl/sar_pkg.sv
// Shared definitions for the SAR conversion sequencer: the one-hot state
// encoding, default converter geometry and a constant-width helper.
package sar_pkg;

   // Default converter geometry
   localparam int SAR_NBITS = 8;
   localparam int SAR_NDEC  = 7;

   // Bit positions of each state inside the one-hot state register
   localparam int IDLE_B    = 0;
   localparam int SAMPLE_B  = 1;
   localparam int PRECH_B   = 2;
   localparam int EVAL_B    = 3;
   localparam int CAPTURE_B = 4;

   // One-hot sequencer states; outputs are decoded straight from these bits
   typedef enum logic [4:0] {
      IDLE    = 5'b00001,
      SAMPLE  = 5'b00010,
      PRECH   = 5'b00100,
      EVAL    = 5'b01000,
      CAPTURE = 5'b10000
   } sar_state_e;

   // Ceiling log2 for sizing counters; callers pass value >= 2
   function automatic int sar_clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) begin
         r = r + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/sar_out_buf.sv
// Result holding register for the SAR sequencer. A new conversion result is
// loaded on 'load'; it is handed downstream with a valid/ready handshake.
// Overwriting a result that has not been accepted raises 'overrun', which
// stays set until the next accepted transfer.
module sar_out_buf
   import sar_pkg::*;
#(
   parameter int NBITS = SAR_NBITS
)
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [NBITS-1:0] d,
   input  logic             ready,
   output logic [NBITS-1:0] dout,
   output logic             valid,
   output logic             overrun
);

   logic [NBITS-1:0] dout_reg;
   logic [NBITS-1:0] dout_next;
   logic             valid_reg;
   logic             valid_next;
   logic             overrun_reg;
   logic             overrun_next;
   logic             xfer;

   // A transfer consumes the held value at this edge
   assign xfer = valid_reg & ready;

   // Each result bit follows d when a capture happens, otherwise holds
   genvar gi;
   generate
      for (gi = 0; gi < NBITS; gi++) begin : g_bit
         assign dout_next[gi] = load ? d[gi] : dout_reg[gi];
      end
   endgenerate

   // A capture always leaves a valid result, even when the old one is
   // consumed at the same edge
   assign valid_next = load | (valid_reg & ~ready);

   // Overrun only when an unconsumed value is overwritten; any transfer
   // (including one coinciding with a capture) clears it
   assign overrun_next = xfer ? 1'b0 : ((load & valid_reg) | overrun_reg);

   // Result, valid and overrun registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dout_reg    <= '0;
         valid_reg   <= 1'b0;
         overrun_reg <= 1'b0;
      end else begin
         dout_reg    <= dout_next;
         valid_reg   <= valid_next;
         overrun_reg <= overrun_next;
      end
   end

   assign dout    = dout_reg;
   assign valid   = valid_reg;
   assign overrun = overrun_reg;

endmodule

// File: rtl/sar_conv_ctrl.sv
// Conversion sequencer for the 8-bit SAR ADC. A start request runs the
// sample phase, then alternating comparator precharge/evaluate cycles (one
// pair per decision) with the SAR register enabled during evaluate, then a
// capture cycle that loads the SAR output into the result buffer.
// A bit whose comparator fails to decide within DEC_TIMEOUT evaluate cycles
// is forced and flagged on timeout_err.
// Optional build macro SAR_CONV_CTRL_CONT_EN: adds the 'cont' input for
// back-to-back conversions without returning to IDLE.
module sar_conv_ctrl
   import sar_pkg::*;
#(
   parameter int SAMPLE_CYCLES = 4,
   parameter int NDEC          = SAR_NDEC,
   parameter int NBITS         = SAR_NBITS,
   parameter int DEC_TIMEOUT   = 3
)
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
`ifdef SAR_CONV_CTRL_CONT_EN
   input  logic             cont,
`endif
   output logic             busy,
   output logic             sample,
   output logic             sar_rst,
   output logic             sar_en,
   output logic             cmp_clk,
   input  logic             op,
   input  logic             om,
   input  logic [NBITS-1:0] d_in,
   output logic [NBITS-1:0] dout,
   output logic             dout_valid,
   input  logic             dout_ready,
   output logic             timeout_err,
   output logic             overrun
);

   localparam int BCW = sar_clog2(NDEC + 1);
   localparam int WCW = sar_clog2(DEC_TIMEOUT + 1);
   localparam int SCW = sar_clog2(SAMPLE_CYCLES + 1);

   localparam logic [BCW-1:0] BIT_LAST  = BCW'(NDEC - 1);
   localparam logic [WCW-1:0] WAIT_LAST = WCW'(DEC_TIMEOUT - 1);
   localparam logic [SCW-1:0] SAMP_LAST = SCW'(SAMPLE_CYCLES - 1);

   sar_state_e     state_reg;
   logic [BCW-1:0] bit_cnt_reg;
   logic [WCW-1:0] wait_cnt_reg;
   logic [SCW-1:0] samp_cnt_reg;
   logic           timeout_err_reg;

   logic           decision;
   logic           forced;
   logic           again;
   logic           capture;

   // Exactly one comparator output high is a decision; both high or both
   // low means the comparator is still resolving
   assign decision = op ^ om;

   // Force the bit on the evaluate cycle that would bring the wait count
   // to DEC_TIMEOUT, so a forced bit spends DEC_TIMEOUT cycles in EVAL
   assign forced = ~decision & (wait_cnt_reg == WAIT_LAST);

`ifdef SAR_CONV_CTRL_CONT_EN
   assign again = cont;
`else
   assign again = 1'b0;
`endif

   // Sequencer: state, bit/wait/sample counters and the sticky timeout flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg       <= IDLE;
         bit_cnt_reg     <= '0;
         wait_cnt_reg    <= '0;
         samp_cnt_reg    <= '0;
         timeout_err_reg <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               bit_cnt_reg  <= '0;
               wait_cnt_reg <= '0;
               samp_cnt_reg <= '0;
               if (start) begin
                  timeout_err_reg <= 1'b0;
                  state_reg       <= SAMPLE;
               end
            end

            SAMPLE: begin
               if (samp_cnt_reg == SAMP_LAST) begin
                  samp_cnt_reg <= '0;
                  state_reg    <= PRECH;
               end else begin
                  samp_cnt_reg <= samp_cnt_reg + 1'b1;
               end
            end

            PRECH: begin
               wait_cnt_reg <= '0;
               state_reg    <= EVAL;
            end

            EVAL: begin
               if (decision || forced) begin
                  bit_cnt_reg  <= bit_cnt_reg + 1'b1;
                  wait_cnt_reg <= '0;
                  if (forced) begin
                     timeout_err_reg <= 1'b1;
                  end
                  state_reg <= (bit_cnt_reg == BIT_LAST) ? CAPTURE : PRECH;
               end else begin
                  wait_cnt_reg <= wait_cnt_reg + 1'b1;
               end
            end

            CAPTURE: begin
               if (again) begin
                  bit_cnt_reg     <= '0;
                  wait_cnt_reg    <= '0;
                  samp_cnt_reg    <= '0;
                  timeout_err_reg <= 1'b0;
                  state_reg       <= SAMPLE;
               end else begin
                  state_reg <= IDLE;
               end
            end

            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

   // Control outputs come straight from one-hot state bits
   assign busy        = ~state_reg[IDLE_B];
   assign sample      = state_reg[SAMPLE_B];
   assign sar_rst     = state_reg[IDLE_B] | state_reg[SAMPLE_B];
   assign sar_en      = state_reg[EVAL_B];
   assign cmp_clk     = state_reg[EVAL_B];
   assign capture     = state_reg[CAPTURE_B];
   assign timeout_err = timeout_err_reg;

   // CAPTURE's closing edge loads the settled SAR output into the buffer
   sar_out_buf #(
      .NBITS (NBITS)
   ) u_out_buf (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (capture),
      .d       (d_in),
      .ready   (dout_ready),
      .dout    (dout),
      .valid   (dout_valid),
      .overrun (overrun)
   );

endmodule

// File: tb/tb_sar_conv_ctrl.sv
// Self-checking bench for sar_conv_ctrl: table of conversions plus
// hand-written sequences for overrun, coincident capture/transfer, ignored
// start and asynchronous reset. Transferred results are checked against a
// scoreboard queue filled when each conversion is launched.
module tb_sar_conv_ctrl;

   localparam int NDEC  = 7;
   localparam int NBITS = 8;

   typedef struct {
      logic [7:0] d;         // value the SAR register presents at capture
      logic [6:0] mask;      // evaluate windows in which the comparator stalls
      logic       both;      // stall level: 1 -> op=om=1, 0 -> op=om=0
      int         start_at;  // lat at which to pulse start mid-conversion (-1 none)
      int         exp_lat;   // expected edges from start edge to capture
      logic       exp_to;    // expected timeout_err after the conversion
   } vec_t;

   logic             clk;
   logic             rst_n;
   logic             start;
   logic             busy;
   logic             sample;
   logic             sar_rst;
   logic             sar_en;
   logic             cmp_clk;
   logic             op = 1'b0;
   logic             om = 1'b0;
   logic [NBITS-1:0] d_in = '0;
   logic [NBITS-1:0] dout;
   logic             dout_valid;
   logic             dout_ready;
   logic             timeout_err;
   logic             overrun;
`ifdef SAR_CONV_CTRL_CONT_EN
   logic             cont;
`endif

   int         checks   = 0;
   int         failures = 0;
   logic [7:0] sb_q[$];

   logic [7:0] cur_d    = 8'h00;
   logic [6:0] cur_mask = 7'h00;
   logic       cur_both = 1'b0;

   vec_t       vec[6];
   int         lat;
   int         ns;
   int         np;
   logic [7:0] dropped;

   sar_conv_ctrl dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
`ifdef SAR_CONV_CTRL_CONT_EN
      .cont        (cont),
`endif
      .busy        (busy),
      .sample      (sample),
      .sar_rst     (sar_rst),
      .sar_en      (sar_en),
      .cmp_clk     (cmp_clk),
      .op          (op),
      .om          (om),
      .d_in        (d_in),
      .dout        (dout),
      .dout_valid  (dout_valid),
      .dout_ready  (dout_ready),
      .timeout_err (timeout_err),
      .overrun     (overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Comparator and SAR register model: decide at once in evaluate unless
   // the current window is masked; present cur_d only once all decisions
   // are done so a premature capture picks up the complement.
   initial begin
      int   pulses;
      logic prev;
      pulses = 0;
      prev   = 1'b0;
      forever begin
         @(negedge clk);
         if (sample) pulses = 0;
         if (cmp_clk && !prev) pulses++;
         prev = cmp_clk;
         if (cmp_clk) begin
            if (pulses >= 1 && pulses <= NDEC && cur_mask[pulses-1]) begin
               op = cur_both;
               om = cur_both;
            end else begin
               op = 1'b1;
               om = 1'b0;
            end
         end else begin
            op = 1'b0;
            om = 1'b0;
         end
         d_in = (pulses == NDEC && !cmp_clk) ? cur_d : ~cur_d;
      end
   end

   // Scoreboard: every accepted transfer must match the oldest expected result
   initial begin
      logic [7:0] exp_v;
      forever begin
         @(negedge clk);
         #1;
         if (rst_n === 1'b1 && dout_valid === 1'b1 && dout_ready === 1'b1) begin
            if (sb_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL sb_extra_xfer actual=%0h required=none", dout);
            end else begin
               exp_v = sb_q.pop_front();
               check("sb_dout", {24'h0, dout}, {24'h0, exp_v});
               $display("xfer dout=%0h expected=%0h", dout, exp_v);
            end
         end
      end
   end

   // Launch one conversion and follow it until busy drops (bounded).
   // lat counts edges after the start edge; returns at the negedge after
   // the capture edge.
   task automatic run_conv(input vec_t v, input bit ready_at_cap,
                           output int lat_o, output int nsamp, output int npulse);
      logic prev_cmp;
      cur_d    = v.d;
      cur_mask = v.mask;
      cur_both = v.both;
      sb_q.push_back(v.d);
      start = 1'b1;
      @(negedge clk);
      start    = 1'b0;
      lat_o    = 0;
      nsamp    = 0;
      npulse   = 0;
      prev_cmp = 1'b0;
      check("start_clears_to", {31'h0, timeout_err}, 32'h0);
      check("busy_after_start", {31'h0, busy}, 32'h1);
      while (busy && lat_o < 200) begin
         if (sample) nsamp++;
         if (cmp_clk && !prev_cmp) npulse++;
         prev_cmp = cmp_clk;
         if (ready_at_cap && npulse == NDEC && !cmp_clk && !sample) dout_ready = 1'b1;
         start = (v.start_at == lat_o);
         @(negedge clk);
         lat_o++;
      end
      start = 1'b0;
      $display("conv d=%0h lat=%0d samples=%0d pulses=%0d dout=%0h valid=%0b to=%0b ovr=%0b",
               v.d, lat_o, nsamp, npulse, dout, dout_valid, timeout_err, overrun);
   endtask

   initial begin
      // d, mask, both, start_at, exp_lat, exp_to
      vec[0] = '{8'hA5, 7'b0000000, 1'b0, -1, 19, 1'b0};
      vec[1] = '{8'h3C, 7'b0001000, 1'b0, -1, 21, 1'b1};
      vec[2] = '{8'h00, 7'b0000000, 1'b0, -1, 19, 1'b0};
      vec[3] = '{8'hFF, 7'b1000001, 1'b1, -1, 23, 1'b1};
      vec[4] = '{8'h5A, 7'b1111111, 1'b0, -1, 33, 1'b1};
      vec[5] = '{8'h81, 7'b0000000, 1'b0, 11, 19, 1'b0};

      rst_n      = 1'b1;
      start      = 1'b0;
      dout_ready = 1'b0;
`ifdef SAR_CONV_CTRL_CONT_EN
      cont       = 1'b0;
`endif
      #2 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_busy",    {31'h0, busy},        32'h0);
      check("rst_sample",  {31'h0, sample},      32'h0);
      check("rst_sar_rst", {31'h0, sar_rst},     32'h1);
      check("rst_sar_en",  {31'h0, sar_en},      32'h0);
      check("rst_cmp_clk", {31'h0, cmp_clk},     32'h0);
      check("rst_valid",   {31'h0, dout_valid},  32'h0);
      check("rst_dout",    {24'h0, dout},        32'h0);
      check("rst_to",      {31'h0, timeout_err}, 32'h0);
      check("rst_ovr",     {31'h0, overrun},     32'h0);
      rst_n = 1'b1;
      @(negedge clk);
      check("idle_sar_rst", {31'h0, sar_rst}, 32'h1);

      // Table-driven single conversions, downstream always ready
      dout_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         run_conv(vec[i], 1'b0, lat, ns, np);
         check("lat",        lat,                        vec[i].exp_lat);
         check("nsample",    ns,                         32'd4);
         check("ncmp",       np,                         NDEC);
         check("valid",      {31'h0, dout_valid},        32'h1);
         check("dout",       {24'h0, dout},              {24'h0, vec[i].d});
         check("timeout",    {31'h0, timeout_err},       {31'h0, vec[i].exp_to});
         check("ovr_clear",  {31'h0, overrun},           32'h0);
         @(negedge clk);
         check("xfer_clears_valid", {31'h0, dout_valid}, 32'h0);
         check("no_extra_conv",     {31'h0, busy},       32'h0);
      end

      // Two captures with downstream stalled: second overwrites, overrun set
      dout_ready = 1'b0;
      run_conv('{8'h11, 7'h00, 1'b0, -1, 19, 1'b0}, 1'b0, lat, ns, np);
      check("ovr_first_valid", {31'h0, dout_valid}, 32'h1);
      check("ovr_first_flag",  {31'h0, overrun},    32'h0);
      run_conv('{8'h22, 7'h00, 1'b0, -1, 19, 1'b0}, 1'b0, lat, ns, np);
      dropped = sb_q.pop_front();
      check("ovr_dout",  {24'h0, dout},       32'h22);
      check("ovr_valid", {31'h0, dout_valid}, 32'h1);
      check("ovr_set",   {31'h0, overrun},    32'h1);
      dout_ready = 1'b1;
      @(negedge clk);
      dout_ready = 1'b0;
      check("ovr_xfer_valid", {31'h0, dout_valid}, 32'h0);
      check("ovr_xfer_clear", {31'h0, overrun},    32'h0);

      // Capture at the same edge as a transfer: new value held, no overrun
      run_conv('{8'h33, 7'h00, 1'b0, -1, 19, 1'b0}, 1'b0, lat, ns, np);
      check("coin_pre_valid", {31'h0, dout_valid}, 32'h1);
      run_conv('{8'h44, 7'h00, 1'b0, -1, 19, 1'b0}, 1'b1, lat, ns, np);
      check("coin_dout",  {24'h0, dout},       32'h44);
      check("coin_valid", {31'h0, dout_valid}, 32'h1);
      check("coin_ovr",   {31'h0, overrun},    32'h0);
      @(negedge clk);
      check("coin_drain", {31'h0, dout_valid}, 32'h0);

      // Asynchronous reset in the middle of an evaluate window
      dout_ready = 1'b0;
      run_conv('{8'h66, 7'h00, 1'b0, -1, 19, 1'b0}, 1'b0, lat, ns, np);
      dropped  = sb_q.pop_front();
      cur_d    = 8'h77;
      cur_mask = 7'h00;
      start    = 1'b1;
      @(negedge clk);
      start = 1'b0;
      begin
         int n;
         n = 0;
         while (!cmp_clk && n < 50) begin
            @(negedge clk);
            n++;
         end
         check("reach_eval", {31'h0, cmp_clk}, 32'h1);
      end
      #2 rst_n = 1'b0;
      #1;
      check("arst_busy",    {31'h0, busy},       32'h0);
      check("arst_sar_rst", {31'h0, sar_rst},    32'h1);
      check("arst_valid",   {31'h0, dout_valid}, 32'h0);
      check("arst_cmp_clk", {31'h0, cmp_clk},    32'h0);
      check("arst_dout",    {24'h0, dout},       32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      dout_ready = 1'b1;
      run_conv(vec[0], 1'b0, lat, ns, np);
      check("post_rst_lat",  lat,           32'd19);
      check("post_rst_dout", {24'h0, dout}, 32'hA5);
      @(negedge clk);

`ifdef SAR_CONV_CTRL_CONT_EN
      // Back-to-back: each capture re-enters SAMPLE, so results arrive every
      // SAMPLE_CYCLES + 2*NDEC + 1 edges; dropping cont ends after the
      // conversion in flight
      begin
         int nval;
         int last;
         int cyc;
         nval     = 0;
         last     = 0;
         cyc      = 0;
         cur_d    = 8'hC3;
         cur_mask = 7'h00;
         repeat (4) sb_q.push_back(8'hC3);
         cont  = 1'b1;
         start = 1'b1;
         @(negedge clk);
         start = 1'b0;
         while (nval < 4 && cyc < 300) begin
            if (dout_valid) begin
               nval++;
               if (nval == 1) check("cont_first_lat", cyc, 32'd19);
               else check("cont_period", cyc - last, 32'd19);
               if (nval < 4) check("cont_busy", {31'h0, busy}, 32'h1);
               last = cyc;
               if (nval == 3) cont = 1'b0;
            end
            @(negedge clk);
            cyc++;
         end
         check("cont_count", nval, 32'd4);
         repeat (3) @(negedge clk);
         check("cont_stopped", {31'h0, busy}, 32'h0);
         check("cont_drained", {31'h0, dout_valid}, 32'h0);
      end
`endif

      check("sb_leftover", sb_q.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
